fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program fetch sequencer with registered decode and ready/valid output
// Optional feature macro: FETCH_SKIP_NOP_EN (skip opcode 1111 instead of presenting it)
module fetch_sequencer #(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [3:0]                       opcode,
  output logic [1:0]                       reg_sel,
  output logic [9:0]                       operand,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] out_pc,
  output logic                             illegal,
  output logic                             busy,
  output logic                             done,
  output logic [BITS_FOR_INSTRUCTIONS:0]   issued_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC  =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);
  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] PC_ONE   = BITS_FOR_INSTRUCTIONS'(1);
  localparam logic [BITS_FOR_INSTRUCTIONS:0]   CNT_ONE  = (BITS_FOR_INSTRUCTIONS + 1)'(1);

  state_t                           state;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc;
  logic                             accept;
  logic                             capture_ok;
  logic                             at_last;
  logic                             skip_nop;
  logic                             decode_illegal;

  assign instruction_address = pc;
  assign accept     = out_valid & out_ready;
  // The output register is free when empty or when its contents leave this cycle.
  assign capture_ok = (state == RUN) && (!out_valid || out_ready);
  assign at_last    = (pc == LAST_PC);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);

`ifdef FETCH_SKIP_NOP_EN
  assign skip_nop = (instruction[3:0] == 4'b1111);
`else
  assign skip_nop = 1'b0;
`endif

  // Flag opcodes outside the supported set; purely informational.
  always_comb begin
    decode_illegal = 1'b1;
    case (instruction[3:0])
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1111: decode_illegal = 1'b0;
      default:                                     decode_illegal = 1'b1;
    endcase
  end

  // Sequencer FSM, program counter, output register and acceptance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      out_valid    <= 1'b0;
      opcode       <= '0;
      reg_sel      <= '0;
      operand      <= '0;
      out_pc       <= '0;
      illegal      <= 1'b0;
      issued_count <= '0;
    end else begin
      if (accept) begin
        issued_count <= issued_count + CNT_ONE;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc           <= '0;
            issued_count <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (capture_ok) begin
            if (skip_nop) begin
              // A capture with out_valid=1 implies acceptance, so the register
              // is always empty afterwards and a final skipped NOP ends the pass.
              if (accept) begin
                out_valid <= 1'b0;
              end
              if (at_last) begin
                state <= DONE;
              end else begin
                pc <= pc + PC_ONE;
              end
            end else begin
              opcode    <= instruction[3:0];
              reg_sel   <= instruction[5:4];
              operand   <= instruction[15:6];
              illegal   <= decode_illegal;
              out_pc    <= pc;
              out_valid <= 1'b1;
              if (at_last) begin
                state <= DRAIN;
              end else begin
                pc <= pc + PC_ONE;
              end
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            out_valid <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed, table-driven bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  instruction_address;
  logic [15:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [1:0]  reg_sel;
  logic [9:0]  operand;
  logic [4:0]  out_pc;
  logic        illegal;
  logic        busy;
  logic        done;
  logic [5:0]  issued_count;

  logic [15:0] prog [32];

  typedef struct {
    logic [15:0] word;
    logic [3:0]  op;
    logic [1:0]  rs;
    logic [9:0]  opnd;
    logic        ill;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [4:0] pc;
    logic [3:0] op;
    logic [1:0] rs;
    logic [9:0] opnd;
    logic       ill;
  } beat_t;

  vec_t  vecs [8];
  beat_t beats_q [$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc;

  always #5 clk = ~clk;

  assign instruction = prog[instruction_address];

  fetch_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .opcode              (opcode),
    .reg_sel             (reg_sel),
    .operand             (operand),
    .out_pc              (out_pc),
    .illegal             (illegal),
    .busy                (busy),
    .done                (done),
    .issued_count        (issued_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fill_prog(input logic [15:0] w);
    for (int i = 0; i < 32; i++) prog[i] = w;
  endtask

  // Pulse start for one cycle; returns at the negedge after the start edge.
  task automatic start_pass();
    @(negedge clk);
    beats_q.delete();
    cyc   = 0;
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
  endtask

  // Run with out_ready=1 until done, recording every accepted beat.
  // poke >= 0 asserts start for one cycle at that cycle index.
  task automatic collect(input int budget, input int poke);
    int n = 0;
    while (!done && n < budget) begin
      start = (cyc == poke);
      if (out_valid && out_ready)
        beats_q.push_back('{cyc, out_pc, opcode, reg_sel, operand, illegal});
      @(negedge clk);
      cyc++;
      n++;
    end
    start = 1'b0;
    if (!done) chk("collect_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 4'h0, 2'b00, 10'h000, 1'b0};
    vecs[1] = '{16'hFF27, 4'h7, 2'b10, 10'h3FC, 1'b0};
    vecs[2] = '{16'h0026, 4'h6, 2'b10, 10'h000, 1'b1};
    vecs[3] = '{16'hFFF8, 4'h8, 2'b11, 10'h3FF, 1'b0};
    vecs[4] = '{16'h0A5A, 4'hA, 2'b01, 10'h029, 1'b1};
    vecs[5] = '{16'h8043, 4'h3, 2'b00, 10'h201, 1'b0};
    vecs[6] = '{16'h00DC, 4'hC, 2'b01, 10'h003, 1'b1};
    vecs[7] = '{16'h0035, 4'h5, 2'b11, 10'h000, 1'b0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    fill_prog(16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", issued_count, 0);
    chk("rst_addr", instruction_address, 0);
    chk("rst_fields", {opcode, reg_sel, operand, out_pc, illegal}, 0);

    // Scenario 2: all ADD, full-rate pass
    out_ready = 1'b1;
    start_pass();
    chk("lat_busy", busy, 1);
    collect(100, -1);
    chk("s2_beats", beats_q.size(), 32);
    if (beats_q.size() == 32) begin
      chk("s2_first_latency", beats_q[0].cyc, 2);
      chk("s2_throughput", beats_q[31].cyc - beats_q[0].cyc, 31);
      for (int i = 0; i < 32; i++) chk($sformatf("s2_pc%0d", i), beats_q[i].pc, i);
    end
    chk("s2_done", done, 1);
    chk("s2_count", issued_count, 32);
    chk("s2_valid_off", out_valid, 0);

    // Scenario 4: decode table at addresses 0..7
    for (int i = 0; i < 8; i++) prog[i] = vecs[i].word;
    start_pass();
    collect(100, -1);
    chk("s4_beats", beats_q.size(), 32);
    if (beats_q.size() == 32) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("s4_pc%0d", i), beats_q[i].pc, i);
        chk($sformatf("s4_op%0d", i), beats_q[i].op, vecs[i].op);
        chk($sformatf("s4_rs%0d", i), beats_q[i].rs, vecs[i].rs);
        chk($sformatf("s4_opnd%0d", i), beats_q[i].opnd, vecs[i].opnd);
        chk($sformatf("s4_ill%0d", i), beats_q[i].ill, vecs[i].ill);
      end
    end

    // Scenario 3: backpressure while out_pc=10 presented
    fill_prog(16'h0000);
    prog[10] = 16'h0029;
    start_pass();
    begin
      int n = 0;
      while (!(out_valid && out_pc == 5'd10) && n < 40) begin
        @(negedge clk); n++;
      end
      if (n >= 40) chk("s3_reach_timeout", 0, 1);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s3_valid", out_valid, 1);
      chk("s3_fields", {out_pc, opcode, reg_sel, operand}, {5'd10, 4'b1001, 2'b10, 10'd0});
      chk("s3_pc_hold", instruction_address, 11);
      chk("s3_count", issued_count, 10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("s3_resume_pc", out_pc, 11);
    chk("s3_resume_op", opcode, 0);
    cyc = 0;
    collect(100, -1);
    chk("s3_done", done, 1);
    chk("s3_count_end", issued_count, 32);

    // Scenario 5: start during RUN ignored; start in DONE restarts
    start_pass();
    collect(100, 6);
    chk("s5_beats", beats_q.size(), 32);
    if (beats_q.size() == 32) chk("s5_last_pc", beats_q[31].pc, 31);
    chk("s5_count", issued_count, 32);
    start_pass();
    @(negedge clk);
    chk("s5_restart_valid", out_valid, 1);
    chk("s5_restart_pc", out_pc, 0);
    chk("s5_restart_count", issued_count, 0);
    chk("s5_restart_done", done, 0);

    // Scenario 1: asynchronous reset mid-pass
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s1_valid", out_valid, 0);
    chk("s1_state", {busy, done}, 0);
    chk("s1_fields", {opcode, reg_sel, operand, out_pc, illegal}, 0);
    chk("s1_count", issued_count, 0);
    chk("s1_addr", instruction_address, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("s1_no_resume_valid", out_valid, 0);
    chk("s1_no_resume_busy", busy, 0);

    // Scenario 6: NOPs at 0 and 11..13
    fill_prog(16'h0000);
    prog[0] = 16'h000F; prog[11] = 16'h000F; prog[12] = 16'h000F; prog[13] = 16'h000F;
    start_pass();
    collect(100, -1);
`ifdef FETCH_SKIP_NOP_EN
    chk("s6_beats", beats_q.size(), 28);
    chk("s6_count", issued_count, 28);
    begin
      int bad = 0;
      foreach (beats_q[i])
        if (beats_q[i].pc inside {5'd0, 5'd11, 5'd12, 5'd13}) bad++;
      chk("s6_skipped_pcs", bad, 0);
    end
    if (beats_q.size() == 28) chk("s6_first_pc", beats_q[0].pc, 1);
`else
    chk("s6_beats", beats_q.size(), 32);
    chk("s6_count", issued_count, 32);
    if (beats_q.size() == 32) begin
      chk("s6_nop0", {beats_q[0].pc, beats_q[0].op, beats_q[0].ill}, {5'd0, 4'hF, 1'b0});
      chk("s6_nop12", {beats_q[12].pc, beats_q[12].op}, {5'd12, 4'hF});
    end
`endif
    chk("s6_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
